// File: rtl/btb_if.sv
// btb_if: fetch lookup, execute update and flush signals of branch_predictor_btb
interface btb_if;
  logic [31:0] pc;
  logic        predicted_outcome;
  logic [31:0] predicted_target;
  logic        predicted_hit;
  logic        update_btb;
  logic [31:0] update_pc;
  logic        branch_outcome;
  logic [31:0] branch_target;
  logic        flush;
  logic        busy;
  modport master (
    output pc, update_btb, update_pc, branch_outcome, branch_target, flush,
    input  predicted_outcome, predicted_target, predicted_hit, busy
  );
  modport slave (
    input  pc, update_btb, update_pc, branch_outcome, branch_target, flush,
    output predicted_outcome, predicted_target, predicted_hit, busy
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: 1/2-way BTB with saturating counters, LRU and flush sweep; BTB_BYPASS_EN forwards same-cycle updates
module branch_predictor_btb #(
  parameter int ENTRIES = 64,
  parameter int WAYS = 2,
  parameter int CTR_W = 2
) (
  input logic CLK,
  input logic RST,
  btb_if.slave bus
);
  localparam int SETS = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1 << (CTR_W - 1));
  typedef enum logic {IDLE, SWEEP} state_t;
  logic             valid_q [WAYS][SETS];
  logic [TAG_W-1:0] tag_q [WAYS][SETS];
  logic [31:0]      tgt_q [WAYS][SETS];
  logic [CTR_W-1:0] ctr_q [WAYS][SETS];
  logic             lru_q [SETS];
  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic             busy_q;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit;
  logic [CTR_W-1:0] l_ctr, o_ctr, n_ctr, r_ctr;
  logic [31:0]      l_tgt, o_tgt, n_tgt, r_tgt;
  logic [WAYS-1:0]  u_hitv, v_sel, u_sel;
  logic             found, u_hit, upd_en, u_write, byp, r_hit;
  assign l_idx = bus.pc[IDX_W+1:2];
  assign l_tag = bus.pc[31:IDX_W+2];
  assign u_idx = bus.update_pc[IDX_W+1:2];
  assign u_tag = bus.update_pc[31:IDX_W+2];
  // fetch lookup across all ways of the indexed set
  always_comb begin
    l_hit = 1'b0;
    l_ctr = '0;
    l_tgt = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[w][l_idx] && tag_q[w][l_idx] == l_tag) begin
        l_hit = 1'b1;
        l_ctr = ctr_q[w][l_idx];
        l_tgt = tgt_q[w][l_idx];
      end
  end
  // update-side hit detection and victim choice: first invalid way, else the LRU way
  always_comb begin
    u_hitv = '0;
    v_sel = '0;
    found = 1'b0;
    o_ctr = '0;
    o_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      u_hitv[w] = valid_q[w][u_idx] && tag_q[w][u_idx] == u_tag;
      if (u_hitv[w]) begin
        o_ctr = ctr_q[w][u_idx];
        o_tgt = tgt_q[w][u_idx];
      end
      if (!found && !valid_q[w][u_idx]) begin
        v_sel[w] = 1'b1;
        found = 1'b1;
      end
    end
    if (!found)
      for (int w = 0; w < WAYS; w++)
        v_sel[w] = WAYS == 1 || w == int'(lru_q[u_idx]);
  end
  assign u_hit = |u_hitv;
  assign u_sel = u_hit ? u_hitv : v_sel;
  assign upd_en = bus.update_btb & ~busy_q & ~bus.flush;
  assign u_write = upd_en & (u_hit | bus.branch_outcome);
  assign n_ctr = !u_hit ? CTR_INIT :
                 bus.branch_outcome ? (o_ctr == CTR_MAX ? o_ctr : o_ctr + CTR_W'(1)) :
                 (o_ctr == '0 ? o_ctr : o_ctr - CTR_W'(1));
  assign n_tgt = bus.branch_outcome ? bus.branch_target : o_tgt;
`ifdef BTB_BYPASS_EN
  assign byp = u_write && bus.update_pc[31:2] == bus.pc[31:2];
`else
  assign byp = 1'b0;
`endif
  assign r_hit = byp | (l_hit & ~busy_q);
  assign r_ctr = byp ? n_ctr : l_ctr;
  assign r_tgt = byp ? n_tgt : l_tgt;
  assign bus.predicted_hit = r_hit;
  assign bus.predicted_outcome = r_hit & r_ctr[CTR_W-1];
  assign bus.predicted_target = bus.predicted_outcome ? r_tgt : bus.pc + 32'd4;
  assign bus.busy = busy_q;
  // flush FSM plus valid/counter/LRU state; sweep clears one set per cycle
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          ctr_q[w][s] <= '0;
        end
      for (int s = 0; s < SETS; s++)
        lru_q[s] <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      busy_q <= 1'b0;
    end else if (state == SWEEP) begin
      for (int w = 0; w < WAYS; w++)
        valid_q[w][cnt] <= 1'b0;
      lru_q[cnt] <= 1'b0;
      cnt <= cnt + IDX_W'(1);
      if (cnt == IDX_W'(SETS - 1)) begin
        state <= IDLE;
        busy_q <= 1'b0;
      end
    end else if (bus.flush) begin
      state <= SWEEP;
      cnt <= '0;
      busy_q <= 1'b1;
    end else if (u_write) begin
      for (int w = 0; w < WAYS; w++)
        if (u_sel[w]) begin
          valid_q[w][u_idx] <= 1'b1;
          ctr_q[w][u_idx] <= n_ctr;
        end
      lru_q[u_idx] <= WAYS == 2 && u_sel[0];
    end
  // tag and target storage, written with the selected way and never reset
  always_ff @(posedge CLK)
    if (u_write)
      for (int w = 0; w < WAYS; w++)
        if (u_sel[w]) begin
          tag_q[w][u_idx] <= u_tag;
          tgt_q[w][u_idx] <= n_tgt;
        end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: drives a 2-way and a direct-mapped BTB (8 entries each) against a recency-list model
module tb_branch_predictor_btb;
  typedef struct {
    logic [29:0] key;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] pc, update_pc, branch_target;
  logic update_btb, branch_outcome, flush;
  int checks = 0;
  int errors = 0;
  int busy_m[2];
  ent_t q[2][8][$];
  logic a_hit[2], a_out[2], a_busy[2];
  logic [31:0] a_tgt[2];
  btb_if b0();
  btb_if b1();
  assign b0.pc = pc;
  assign b0.update_btb = update_btb;
  assign b0.update_pc = update_pc;
  assign b0.branch_outcome = branch_outcome;
  assign b0.branch_target = branch_target;
  assign b0.flush = flush;
  assign b1.pc = pc;
  assign b1.update_btb = update_btb;
  assign b1.update_pc = update_pc;
  assign b1.branch_outcome = branch_outcome;
  assign b1.branch_target = branch_target;
  assign b1.flush = flush;
  assign a_hit[0] = b0.predicted_hit;
  assign a_out[0] = b0.predicted_outcome;
  assign a_tgt[0] = b0.predicted_target;
  assign a_busy[0] = b0.busy;
  assign a_hit[1] = b1.predicted_hit;
  assign a_out[1] = b1.predicted_outcome;
  assign a_tgt[1] = b1.predicted_target;
  assign a_busy[1] = b1.busy;
  branch_predictor_btb #(.ENTRIES(8), .WAYS(2), .CTR_W(2)) dut0 (.CLK(clk), .RST(rst), .bus(b0));
  branch_predictor_btb #(.ENTRIES(8), .WAYS(1), .CTR_W(2)) dut1 (.CLK(clk), .RST(rst), .bus(b1));
  initial forever #5 clk = ~clk;
  function automatic int sets_of(int c);
    return c == 0 ? 4 : 8;
  endfunction
  function automatic int ways_of(int c);
    return c == 0 ? 2 : 1;
  endfunction
  function automatic int slot(int c, logic [31:0] a);
    return int'(a[5:2]) % sets_of(c);
  endfunction
  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      busy_m[c] = 0;
      for (int s = 0; s < 8; s++) q[c][s].delete();
    end
  endfunction
  // each set is a most-recent-first list; eviction drops the tail
  function automatic void model_update(int c, logic [31:0] up, logic tk, logic [31:0] bt);
    int s = slot(c, up);
    int f = -1;
    ent_t e;
    for (int i = 0; i < q[c][s].size(); i++)
      if (q[c][s][i].key == up[31:2]) f = i;
    if (f >= 0) begin
      e = q[c][s][f];
      e.ctr = tk ? (e.ctr == 3 ? 3 : e.ctr + 1) : (e.ctr == 0 ? 0 : e.ctr - 1);
      if (tk) e.tgt = bt;
      q[c][s].delete(f);
      q[c][s].push_front(e);
    end else if (tk) begin
      if (q[c][s].size() == ways_of(c)) void'(q[c][s].pop_back());
      e.key = up[31:2];
      e.tgt = bt;
      e.ctr = 2;
      q[c][s].push_front(e);
    end
  endfunction
  function automatic void predict(int c, logic [31:0] p, output logic h, output logic o, output logic [31:0] t);
    int s = slot(c, p);
    h = 1'b0;
    o = 1'b0;
    t = p + 32'd4;
    for (int i = 0; i < q[c][s].size(); i++)
      if (q[c][s][i].key == p[31:2]) begin
        h = 1'b1;
        o = q[c][s][i].ctr >= 2;
        if (o) t = q[c][s][i].tgt;
      end
  endfunction
  function automatic void expect_out(int c, output logic h, output logic o, output logic [31:0] t);
    h = 1'b0;
    o = 1'b0;
    t = pc + 32'd4;
    if (busy_m[c] > 0) return;
`ifdef BTB_BYPASS_EN
    if (update_btb && !flush && update_pc[31:2] == pc[31:2]) begin
      int s = slot(c, update_pc);
      ent_t save[$] = q[c][s];
      model_update(c, update_pc, branch_outcome, branch_target);
      predict(c, pc, h, o, t);
      q[c][s] = save;
      return;
    end
`endif
    predict(c, pc, h, o, t);
  endfunction
  function automatic void model_edge();
    if (rst) return;
    for (int c = 0; c < 2; c++)
      if (busy_m[c] > 0) busy_m[c]--;
      else if (flush) begin
        busy_m[c] = sets_of(c);
        for (int s = 0; s < 8; s++) q[c][s].delete();
      end else if (update_btb) model_update(c, update_pc, branch_outcome, branch_target);
  endfunction
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle();
    update_btb = 1'b0;
    flush = 1'b0;
    branch_outcome = 1'b0;
    update_pc = '0;
    branch_target = '0;
  endtask
  task automatic upd(logic [31:0] up, logic tk, logic [31:0] bt);
    update_btb = 1'b1;
    update_pc = up;
    branch_outcome = tk;
    branch_target = bt;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_reset();
    logic eh, eo;
    logic [31:0] et;
    rst = 1'b1;
    idle();
    pc = 32'h100;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        expect_out(c, eh, eo, et);
        checks++;
        if ({a_hit[c], a_out[c], a_tgt[c], a_busy[c]} !== {eh, eo, et, 1'b0}) begin
          errors++;
          $display("FAIL reset dut%0d: hit/out/tgt/busy %b/%b/%h/%b, expected %b/%b/%h/0", c, a_hit[c], a_out[c], a_tgt[c], a_busy[c], eh, eo, et);
        end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
  endtask
  task automatic test_counter();
    logic eh, eo;
    logic [31:0] et;
    do_reset();
    pc = 32'h200;
    upd(32'h200, 1'b1, 32'h800);
    tick();
    for (int k = 0; k < 5; k++) begin
      idle();
      #1;
      for (int c = 0; c < 2; c++) begin
        expect_out(c, eh, eo, et);
        checks++;
        if ({a_hit[c], a_out[c], a_tgt[c]} !== {eh, eo, et}) begin
          errors++;
          $display("FAIL counter step%0d dut%0d: hit/out/tgt %b/%b/%h, expected %b/%b/%h", k, c, a_hit[c], a_out[c], a_tgt[c], eh, eo, et);
        end
      end
      if (k < 3) upd(32'h200, 1'b0, 32'h0);
      else upd(32'h200, 1'b1, 32'h900);
      tick();
    end
  endtask
  task automatic test_lru();
    logic eh, eo;
    logic [31:0] et;
    logic [31:0] seq[6] = '{32'h1000, 32'h2000, 32'h3000, 32'h2000, 32'h4000, 32'h60};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      upd(seq[k], 1'b1, 32'h8000 + 32'(k) * 32'h10);
      tick();
      idle();
      for (int p = 0; p < 6; p++) begin
        pc = seq[p];
        #1;
        for (int c = 0; c < 2; c++) begin
          expect_out(c, eh, eo, et);
          checks++;
          if ({a_hit[c], a_out[c], a_tgt[c]} !== {eh, eo, et}) begin
            errors++;
            $display("FAIL lru alloc%0d dut%0d pc=%h: hit/out/tgt %b/%b/%h, expected %b/%b/%h", k, c, pc, a_hit[c], a_out[c], a_tgt[c], eh, eo, et);
          end
        end
      end
    end
  endtask
  task automatic test_flush();
    logic eh, eo;
    logic [31:0] et;
    logic [31:0] pcs[6] = '{32'h100, 32'h104, 32'h108, 32'h10c, 32'h500, 32'h600};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      upd(pcs[k], 1'b1, 32'hA000 + 32'(k));
      tick();
    end
    idle();
    flush = 1'b1;
    upd(32'h500, 1'b1, 32'hB000);
    tick();
    for (int k = 0; k < 11; k++) begin
      idle();
      if (k == 1) upd(32'h600, 1'b1, 32'hC000);
      if (k == 2) flush = 1'b1;
      pc = pcs[k % 6];
      #1;
      for (int c = 0; c < 2; c++) begin
        expect_out(c, eh, eo, et);
        checks++;
        if ({a_busy[c], a_hit[c], a_out[c], a_tgt[c]} !== {busy_m[c] > 0, eh, eo, et}) begin
          errors++;
          $display("FAIL flush cyc%0d dut%0d: busy/hit/out/tgt %b/%b/%b/%h, expected %b/%b/%b/%h", k, c, a_busy[c], a_hit[c], a_out[c], a_tgt[c], busy_m[c] > 0, eh, eo, et);
        end
      end
      tick();
    end
    idle();
    for (int p = 0; p < 6; p++) begin
      pc = pcs[p];
      #1;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if ({a_hit[c], a_tgt[c]} !== {1'b0, pcs[p] + 32'd4}) begin
          errors++;
          $display("FAIL post_flush dut%0d pc=%h: hit/tgt %b/%h, expected 0/%h", c, pc, a_hit[c], a_tgt[c], pcs[p] + 32'd4);
        end
      end
    end
  endtask
  task automatic test_reset_mid_sweep();
    logic eh, eo;
    logic [31:0] et;
    do_reset();
    upd(32'h11c, 1'b1, 32'hD000);
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    pc = 32'h11c;
    #1;
    for (int c = 0; c < 2; c++) begin
      expect_out(c, eh, eo, et);
      checks++;
      if ({a_busy[c], a_hit[c], a_out[c], a_tgt[c]} !== {1'b0, eh, eo, et}) begin
        errors++;
        $display("FAIL reset_mid_sweep dut%0d: busy/hit/out/tgt %b/%b/%b/%h, expected 0/%b/%b/%h", c, a_busy[c], a_hit[c], a_out[c], a_tgt[c], eh, eo, et);
      end
    end
    tick();
    rst = 1'b0;
  endtask
  task automatic test_same_cycle();
    logic eh, eo;
    logic [31:0] et;
    do_reset();
    pc = 32'h300;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) upd(32'h300, 1'b1, 32'hE000);
      else idle();
      #1;
      for (int c = 0; c < 2; c++) begin
        expect_out(c, eh, eo, et);
        checks++;
        if ({a_hit[c], a_out[c], a_tgt[c]} !== {eh, eo, et}) begin
          errors++;
          $display("FAIL same_cycle cyc%0d dut%0d: hit/out/tgt %b/%b/%h, expected %b/%b/%h", k, c, a_hit[c], a_out[c], a_tgt[c], eh, eo, et);
        end
      end
      tick();
    end
  endtask
  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction
  task automatic test_random();
    logic eh, eo;
    logic [31:0] et;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      pc = rpc();
      update_btb = 1'($urandom_range(0, 1));
      update_pc = $urandom_range(0, 3) == 0 ? pc : rpc();
      branch_outcome = $urandom_range(0, 9) < 6;
      branch_target = $urandom;
      flush = $urandom_range(0, 39) == 0;
      #1;
      for (int c = 0; c < 2; c++) begin
        expect_out(c, eh, eo, et);
        checks++;
        if ({a_busy[c], a_hit[c], a_out[c], a_tgt[c]} !== {busy_m[c] > 0, eh, eo, et}) begin
          errors++;
          $display("FAIL random cyc%0d dut%0d pc=%h: busy/hit/out/tgt %b/%b/%b/%h, expected %b/%b/%b/%h", k, c, pc, a_busy[c], a_hit[c], a_out[c], a_tgt[c], busy_m[c] > 0, eh, eo, et);
        end
      end
      tick();
    end
    idle();
  endtask
  initial begin
    rst = 1'b1;
    pc = '0;
    idle();
    test_reset();
    test_counter();
    test_lru();
    test_flush();
    test_reset_mid_sweep();
    test_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
